// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: bundles the three buses of the ALU control unit.
//   Instruction channel : instr_valid / instr_ready / instr
//   ALU channel         : alu_op / alu_a / alu_b / alu_c out, alu_ans1 / alu_ans2 / alu_z / alu_n in
//   Retire / flags      : done / illegal / wb_addr / wb_data, flag_c / flag_z / flag_n
// Modports:
//   master : the environment (instruction source plus the combinational ALU)
//   slave  : the control unit itself
interface alu_control_unit_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    logic [5:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_c;
    logic [31:0] alu_ans1;
    logic        alu_ans2;
    logic        alu_z;
    logic        alu_n;

    logic        done;
    logic        illegal;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;

    modport master (
        output instr_valid, instr, alu_ans1, alu_ans2, alu_z, alu_n,
        input  instr_ready, alu_op, alu_a, alu_b, alu_c,
        input  done, illegal, wb_addr, wb_data, flag_c, flag_z, flag_n
    );

    modport slave (
        input  instr_valid, instr, alu_ans1, alu_ans2, alu_z, alu_n,
        output instr_ready, alu_op, alu_a, alu_b, alu_c,
        output done, illegal, wb_addr, wb_data, flag_c, flag_z, flag_n
    );
endinterface

// File: rtl/alu_control_unit.sv
// alu_control_unit: sequences one instruction at a time through an external combinational
// 32-bit ALU. IDLE accepts an instruction, DECODE reads operands from the register file,
// EXEC drives the ALU for a full cycle, WB reports the retired result for one cycle.
// Owns the architectural carry/zero/negative flags.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   bus        : alu_control_unit_if.slave (instruction, ALU and retire/flag signals)
// Optional build macro ALU_CU_DEBUG_PORT_EN adds:
//   dbg_raddr  : debug register read index
//   dbg_rdata  : combinational register read data (R0 and out-of-range indices read 0)
module alu_control_unit #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IMM_W    = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_control_unit_if.slave         bus
`ifdef ALU_CU_DEBUG_PORT_EN
    ,
    input  logic [3:0]                dbg_raddr,
    output logic [31:0]               dbg_rdata
`endif
);

    localparam logic [5:0] OpAdd = 6'b010000;
    localparam logic [5:0] OpSub = 6'b010001;
    localparam logic [5:0] OpEq  = 6'b100000;
    localparam logic [5:0] OpNe  = 6'b100001;
    localparam logic [5:0] OpLe  = 6'b100010;
    localparam logic [5:0] OpGt  = 6'b100011;
    localparam logic [5:0] OpLls = 6'b110000;
    localparam logic [5:0] OpLrs = 6'b110001;
    localparam logic [5:0] OpArs = 6'b110010;

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    // Sized for the full 4-bit index; entries 0 and >= NUM_REGS are never written.
    logic [31:0] regs_q [16];
    logic        flag_c_q, flag_z_q, flag_n_q;
    logic [5:0]  alu_op_q;
    logic [31:0] alu_a_q, alu_b_q;
    logic        alu_c_q;
    logic        done_q, illegal_q;
    logic [3:0]  wb_addr_q;
    logic [31:0] wb_data_q;

    logic [5:0]  opcode;
    logic [3:0]  rd, rs1, rs2;
    logic        use_carry, imm_sel;
    logic [31:0] imm_ext, rs1_val, rs2_val, op_b;
    logic        op_legal, op_arith, rd_writable;

    assign opcode    = instr_q[31:26];
    assign rd        = instr_q[25:22];
    assign rs1       = instr_q[21:18];
    assign rs2       = instr_q[17:14];
    assign use_carry = instr_q[13];
    assign imm_sel   = instr_q[12];
    assign imm_ext   = 32'(instr_q[IMM_W-1:0]);

    assign rs1_val     = (rs1 != 4'd0 && 32'(rs1) < NUM_REGS) ? regs_q[rs1] : '0;
    assign rs2_val     = (rs2 != 4'd0 && 32'(rs2) < NUM_REGS) ? regs_q[rs2] : '0;
    assign op_b        = imm_sel ? imm_ext : rs2_val;
    assign rd_writable = (rd != 4'd0) && (32'(rd) < NUM_REGS);
    assign op_arith    = (opcode == OpAdd) || (opcode == OpSub);

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OpAdd, OpSub, OpEq, OpNe, OpLe, OpGt, OpLls, OpLrs, OpArs: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.instr_valid) state_d = StDecode;
            StDecode: state_d = op_legal ? StExec : StWb;
            StExec:   state_d = StWb;
            StWb:     state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            alu_op_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_c_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.instr_valid) instr_q <= bus.instr;
                end
                StDecode: begin
                    if (op_legal) begin
                        // Flags only change at retire, so flag_c here equals its value at accept.
                        alu_op_q <= opcode;
                        alu_a_q  <= rs1_val;
                        alu_b_q  <= op_b;
                        alu_c_q  <= use_carry & flag_c_q;
                    end else begin
                        done_q    <= 1'b1;
                        illegal_q <= 1'b1;
                        wb_addr_q <= rd;
                        wb_data_q <= '0;
                    end
                end
                StExec: begin
                    // Sample the ALU at the end of the EXEC cycle; results show during WB.
                    done_q    <= 1'b1;
                    wb_addr_q <= rd;
                    wb_data_q <= bus.alu_ans1;
                    flag_z_q  <= bus.alu_z;
                    flag_n_q  <= bus.alu_n;
                    if (op_arith) flag_c_q <= bus.alu_ans2;
                    if (rd_writable) regs_q[rd] <= bus.alu_ans1;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = (state_q == StIdle) && rst_n;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_c       = alu_c_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.flag_c      = flag_c_q;
    assign bus.flag_z      = flag_z_q;
    assign bus.flag_n      = flag_n_q;

`ifdef ALU_CU_DEBUG_PORT_EN
    assign dbg_rdata = (dbg_raddr != 4'd0 && 32'(dbg_raddr) < NUM_REGS) ? regs_q[dbg_raddr] : '0;
`endif

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: directed vectors, expected retire records
// queued at issue and checked by an independent monitor on every done pulse.
module tb_alu_control_unit;

    localparam logic [5:0] ADD = 6'h10, SUB = 6'h11, EQ = 6'h20, NE = 6'h21, LE = 6'h22;
    localparam logic [5:0] GT = 6'h23, LLS = 6'h30, LRS = 6'h31, ARS = 6'h32;

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  rd, rs1, rs2;
        logic        uc, isel;
        logic [11:0] imm;
        logic [31:0] data;
        logic        ill, c, z, n;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_control_unit_if bus ();

`ifdef ALU_CU_DEBUG_PORT_EN
    logic [3:0]  dbg_raddr = 4'd0;
    logic [31:0] dbg_rdata;
    alu_control_unit #(.NUM_REGS(16), .IMM_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );
`else
    alu_control_unit #(.NUM_REGS(16), .IMM_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
`endif

    // Combinational ALU model.
    always_comb begin
        bus.alu_ans1 = '0;
        bus.alu_ans2 = 1'b0;
        case (bus.alu_op)
            ADD: {bus.alu_ans2, bus.alu_ans1} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}
                                                + 33'(bus.alu_c);
            SUB: {bus.alu_ans2, bus.alu_ans1} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}
                                                - 33'(bus.alu_c);
            EQ:  bus.alu_ans1 = {31'd0, bus.alu_a == bus.alu_b};
            NE:  bus.alu_ans1 = {31'd0, bus.alu_a != bus.alu_b};
            LE:  bus.alu_ans1 = {31'd0, $signed(bus.alu_a) <= $signed(bus.alu_b)};
            GT:  bus.alu_ans1 = {31'd0, $signed(bus.alu_a) > $signed(bus.alu_b)};
            LLS: bus.alu_ans1 = bus.alu_a << bus.alu_b;
            LRS: bus.alu_ans1 = bus.alu_a >> bus.alu_b;
            ARS: bus.alu_ans1 = $unsigned($signed(bus.alu_a) >>> bus.alu_b);
            default: ;
        endcase
        bus.alu_z = (bus.alu_ans1 == 32'd0);
        bus.alu_n = bus.alu_ans1[31];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                input logic [3:0] rs2, input logic uc, input logic isel,
                                input logic [11:0] imm, input logic [31:0] data, input logic ill,
                                input logic c, input logic z, input logic n);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.uc = uc; v.isel = isel;
        v.imm = imm; v.data = data; v.ill = ill; v.c = c; v.z = z; v.n = n;
        return v;
    endfunction

    function automatic logic [31:0] enc(input vec_t v);
        return {v.op, v.rd, v.rs1, v.rs2, v.uc, v.isel, v.imm};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got wb_addr %h wb_data %h, expected no retire",
                         bus.wb_addr, bus.wb_data);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("wb_addr", 32'(bus.wb_addr), 32'(e.rd));
                chk("wb_data", bus.wb_data, e.data);
                chk("illegal", 32'(bus.illegal), 32'(e.ill));
                chk("flag_c", 32'(bus.flag_c), 32'(e.c));
                chk("flag_z", 32'(bus.flag_z), 32'(e.z));
                chk("flag_n", 32'(bus.flag_n), 32'(e.n));
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!bus.instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
    endtask

    task automatic issue(input vec_t v);
        int  k;
        bit  seen;
        exp_q.push_back(v);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = enc(v);
        wait_ready();
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        seen = 1'b0;
        k    = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                k    = i;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (!v.ill) chk("latency", 32'(k), 32'd3);
        @(negedge clk);
        chk("ready_after_done", 32'(bus.instr_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t grp_a[$];
        vec_t grp_b[$];
        vec_t grp_c[$];
        int   acc[3];
        int   dc0;

        //               op   rd rs1 rs2 uc is imm     data          il c  z  n
        grp_a.push_back(mk(ADD, 1, 0, 0, 0, 1, 12'hFFF, 32'h00000FFF, 0, 0, 0, 0));
        grp_a.push_back(mk(SUB, 1, 0, 0, 0, 1, 12'h001, 32'hFFFFFFFF, 0, 1, 0, 1));
        grp_a.push_back(mk(ADD, 2, 1, 0, 0, 1, 12'h001, 32'h00000000, 0, 1, 1, 0));
        grp_a.push_back(mk(ADD, 3, 0, 0, 1, 1, 12'h000, 32'h00000001, 0, 0, 0, 0));
        grp_a.push_back(mk(SUB, 6, 0, 0, 0, 1, 12'h001, 32'hFFFFFFFF, 0, 1, 0, 1));
        grp_a.push_back(mk(LLS, 1, 3, 0, 0, 1, 12'd31,  32'h80000000, 0, 1, 0, 1));
        grp_a.push_back(mk(ARS, 4, 1, 0, 0, 1, 12'd4,   32'hF8000000, 0, 1, 0, 1));
        grp_a.push_back(mk(EQ,  5, 1, 1, 0, 0, 12'h000, 32'h00000001, 0, 1, 0, 0));
        grp_a.push_back(mk(LRS, 7, 1, 0, 0, 1, 12'd4,   32'h08000000, 0, 1, 0, 0));
        grp_a.push_back(mk(GT,  8, 1, 3, 0, 0, 12'h000, 32'h00000000, 0, 1, 1, 0));
        grp_a.push_back(mk(NE,  9, 1, 3, 0, 0, 12'h000, 32'h00000001, 0, 1, 0, 0));
        grp_a.push_back(mk(LE, 10, 1, 3, 0, 0, 12'h000, 32'h00000001, 0, 1, 0, 0));
        grp_a.push_back(mk(ADD,11, 4, 0, 0, 1, 12'h000, 32'hF8000000, 0, 0, 0, 1));
        grp_a.push_back(mk(6'h3F,12,1, 1, 0, 0, 12'h000, 32'h00000000, 1, 0, 0, 1));
        grp_a.push_back(mk(ADD,13,12, 0, 0, 1, 12'h000, 32'h00000000, 0, 0, 1, 0));
        grp_a.push_back(mk(6'h12,5, 1, 1, 0, 0, 12'h000, 32'h00000000, 1, 0, 1, 0));
        grp_a.push_back(mk(ADD,14, 5, 0, 0, 1, 12'h000, 32'h00000001, 0, 0, 0, 0));
        grp_a.push_back(mk(SUB, 6, 0, 0, 0, 1, 12'h001, 32'hFFFFFFFF, 0, 1, 0, 1));
        // After reset mid-instruction: registers and flags must be zero.
        grp_b.push_back(mk(ADD,15, 1, 6, 1, 0, 12'h000, 32'h00000000, 0, 0, 1, 0));
        // Back-to-back with instr_valid held high.
        grp_c.push_back(mk(ADD, 0, 0, 0, 0, 1, 12'h123, 32'h00000123, 0, 0, 0, 0));
        grp_c.push_back(mk(ADD, 1, 0, 0, 0, 0, 12'h000, 32'h00000000, 0, 0, 1, 0));
        grp_c.push_back(mk(SUB, 2, 1, 0, 0, 1, 12'h010, 32'hFFFFFFF0, 0, 1, 0, 1));

        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flags", {29'd0, bus.flag_c, bus.flag_z, bus.flag_n}, 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(bus.instr_ready), 32'd1);

        foreach (grp_a[i]) issue(grp_a[i]);

        // Reset during EXEC of an ADD: no retire, state cleared.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = enc(mk(ADD, 2, 0, 0, 0, 1, 12'h005, 32'h5, 0, 0, 0, 0));
        wait_ready();
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("inrst_ready", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        chk("inrst_done", 32'(bus.done), 32'd0);
        chk("inrst_flags", {29'd0, bus.flag_c, bus.flag_z, bus.flag_n}, 32'd0);
        chk("inrst_alu_b", bus.alu_b, 32'd0);
        chk("inrst_alu_op", 32'(bus.alu_op), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", 32'(bus.instr_ready), 32'd1);
        chk("done_after_midrst", 32'(bus.done), 32'd0);

        foreach (grp_b[i]) issue(grp_b[i]);

        dc0 = done_cnt;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.instr = enc(grp_c[i]);
            exp_q.push_back(grp_c[i]);
            wait_ready();
            @(posedge clk);
            #1 acc[i] = cyc;
            if (i == 2) bus.instr_valid = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("b2b_spacing_01", 32'(acc[1] - acc[0]), 32'd4);
        chk("b2b_spacing_12", 32'(acc[2] - acc[1]), 32'd4);
        chk("b2b_done_count", 32'(done_cnt - dc0), 32'd3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
Sequencing control unit that drives the combinational 32-bit ALU (opCode/a/b/c in, ans1/ans2/z/n out) from the issuing side.
- Accepts one instruction per valid/ready handshake and decodes it.
- Reads operands from an internal register file and presents them to the ALU for a full cycle.
- Samples the result and flags, then writes back to the register file.
- Sits between the instruction source and the ALU and owns the architectural carry/zero/negative flags.

Parameters:
- NUM_REGS, 16: register file depth; legal range 2..16, since register fields are 4 bits.
- IMM_W, 12: immediate field width; the immediate is zero-extended to 32 bits.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- instr_valid, input, 1: instruction word is valid.
- instr_ready, output, 1: unit can accept an instruction.
- instr, input, 32: instruction word. Fields: [31:26] opcode, [25:22] rd, [21:18] rs1, [17:14] rs2, [13] use_carry, [12] imm_sel, [11:0] imm.
- alu_op, output, 6: opcode to ALU.
- alu_a, output, 32: operand A to ALU.
- alu_b, output, 32: operand B or shift amount to ALU.
- alu_c, output, 1: carry/borrow-in to ALU.
- alu_ans1, input, 32: ALU result.
- alu_ans2, input, 1: ALU carry-out/borrow-out.
- alu_z, input, 1: ALU zero flag.
- alu_n, input, 1: ALU negative flag.
- done, output, 1: one-cycle pulse when an instruction retires (legal or illegal).
- illegal, output, 1: qualifies done; the retired opcode was unsupported.
- wb_addr, output, 4: destination register of the retired instruction.
- wb_data, output, 32: value written, valid with done.
- flag_c, output, 1: architectural carry flag.
- flag_z, output, 1: architectural zero flag.
- flag_n, output, 1: architectural negative flag.

Behaviour:
- Legal opcodes:
  - 010000 ADD, 010001 SUB
  - 100000 EQ, 100001 NE, 100010 LE, 100011 GT
  - 110000 LLS, 110001 LRS, 110010 ARS
  - Every other value is illegal.
- FSM states IDLE -> DECODE -> EXEC -> WB -> IDLE. Encoding is free.
- IDLE:
  - instr_ready=1.
  - On instr_valid && instr_ready, latch instr and go to DECODE.
  - instr_ready=0 in all other states; instr is ignored outside IDLE.
- DECODE:
  - Read rs1 and rs2; register 0 always reads 0.
  - Register indices >= NUM_REGS read 0.
  - Operand B = imm_sel ? zero-extended imm : R[rs2].
  - Check opcode legality.
  - If illegal, go to WB with no ALU use.
- EXEC:
  - Drive alu_op, alu_a, alu_b, alu_c from registers, stable for the whole cycle.
  - alu_c = use_carry ? flag_c : 0, using flag_c as of instruction acceptance.
- WB, legal opcode:
  - Capture alu_ans1 into R[rd], except no write when rd=0 or rd >= NUM_REGS.
  - flag_z <= alu_z; flag_n <= alu_n.
  - flag_c <= alu_ans2 only for ADD/SUB; otherwise unchanged.
  - done=1, wb_addr=rd, wb_data=alu_ans1; this applies even when the write is suppressed.
- WB, illegal opcode:
  - done=1, illegal=1, wb_data=0.
  - No register write and no flag change.
- Latency: handshake accepted at edge T -> done high in the cycle after edge T+2, i.e. 3 cycles.
  - Throughput is 1 instruction per 4 cycles.
  - instr_ready returns high the cycle after done.
- Idle ALU drive: outside EXEC, alu_op/alu_a/alu_b/alu_c hold their last values. Reset value is 0.
- Comparison results are used as returned (0 or 1 in bit 0). Shifts pass the full 32-bit alu_b as the amount; no masking in this unit.
- Reset (rst_n=0 at an edge, in any state including mid-instruction):
  - State goes to IDLE; any in-flight instruction is discarded with no done pulse.
  - All registers and flags are cleared to 0.
  - done, illegal, wb_addr, wb_data, alu_* are cleared to 0.
  - instr_ready is 0 while rst_n=0, and 1 from the first cycle after release.
- Simultaneous events: instr_valid held high through WB is not accepted until back in IDLE. No pipelining or overlap.

Optional Feature:
ALU_CU_DEBUG_PORT_EN.
- Defined: adds input dbg_raddr (4 bits) and output dbg_rdata (32 bits).
  - Combinational read of R[dbg_raddr]; register 0 and out-of-range indices return 0.
  - No effect on the FSM.
- Undefined: the ports do not exist and register contents are observable only through wb_data.

Test Plan:
1. After reset, R1=R2=0. Issue ADD rd=1, rs1=0, imm_sel=1, imm=0xFFF -> done after 3 cycles, wb_data=0x00000FFF, flag_z=0, flag_n=0, flag_c=0.
2. Set R1=0xFFFFFFFF via the register-load sequence, then ADD rd=2, rs1=1, imm=1 -> R2=0, flag_z=1, flag_c=1. Next, ADD rd=3, rs1=0, imm=0, use_carry=1 -> wb_data=1, flag_c=0.
3. R1=0x80000000, ARS rd=4, rs1=1, imm=4 -> wb_data=0xF8000000, flag_n=1, flag_c unchanged. EQ rd=5, rs1=1, rs2=1 -> wb_data=1.
4. Opcode 0x3F -> done=1, illegal=1, wb_data=0. No register or flag change; instr_ready high the next cycle.
5. Assert rst_n=0 during EXEC of an ADD -> no done pulse; flags and registers are 0; instr_ready=1 one cycle after release.
6. Hold instr_valid high continuously with 3 back-to-back instructions -> exactly 3 done pulses, 4 cycles apart. Write to rd=0 reports wb_addr=0 and R0 still reads 0.
